// File: rtl/cpu_muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
package cpu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } muldiv_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } md_state_t;

  localparam int DIV_CYCLES = 32;

  // Ops that occupy the unit for more than the accept cycle.
  function automatic logic is_md_op(input logic [2:0] op);
    return op <= 3'd3;
  endfunction

endpackage

// File: rtl/div_radix2.sv
// Restoring radix-2 divider on unsigned magnitudes, one quotient bit per step.
module div_radix2
  import cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] quot_o,
  output logic [WIDTH-1:0] rem_o,
  output logic             last_o
);

  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;

  // quot_q starts as the dividend; its MSB feeds the partial remainder while
  // quotient bits shift in at the bottom.
  always_comb begin
    rem_d  = rem_q;
    quot_d = quot_q;
    dvs_d  = dvs_q;
    cnt_d  = cnt_q;
    trial  = {rem_q, quot_q[WIDTH-1]};
    diff   = trial - {1'b0, dvs_q};
    if (load_i) begin
      rem_d  = '0;
      quot_d = dividend_i;
      dvs_d  = divisor_i;
      cnt_d  = '0;
    end else if (step_i) begin
      if (!diff[WIDTH]) begin
        rem_d  = diff[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b1};
      end else begin
        rem_d  = trial[WIDTH-1:0];
        quot_d = {quot_q[WIDTH-2:0], 1'b0};
      end
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rem_q  <= '0;
      quot_q <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
    end else begin
      rem_q  <= rem_d;
      quot_q <= quot_d;
      dvs_q  <= dvs_d;
      cnt_q  <= cnt_d;
    end
  end

  assign quot_o = quot_q;
  assign rem_o  = rem_q;
  assign last_o = (cnt_q == {CNT_W{1'b1}});

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO architectural registers with a 2-cycle multiply and 34-cycle divide.
module hilo_muldiv
  import cpu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start_i,
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] src_a_i,
  input  logic [WIDTH-1:0] src_b_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  md_state_t        state_q, state_d;
  muldiv_op_t       op_q, op_in;
  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic             accept, done, stall;

  assign op_in  = muldiv_op_t'(op_i);
  assign accept = start_i & ~flush_i & (state_q == ST_IDLE);

  // Divider is loaded with magnitudes straight from the operand bus at T0.
  logic             in_sgn, div_load, div_last;
  logic [WIDTH-1:0] a_mag, b_mag, quot, rem;

  assign in_sgn   = (op_in == OP_DIV);
  assign a_mag    = (in_sgn & src_a_i[WIDTH-1]) ? -src_a_i : src_a_i;
  assign b_mag    = (in_sgn & src_b_i[WIDTH-1]) ? -src_b_i : src_b_i;
  assign div_load = accept & (op_in == OP_DIV || op_in == OP_DIVU);

  div_radix2 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_div (
    .clk       (clk),
    .resetn    (resetn),
    .load_i    (div_load),
    .step_i    (state_q == ST_DIV),
    .dividend_i(a_mag),
    .divisor_i (b_mag),
    .quot_o    (quot),
    .rem_o     (rem),
    .last_o    (div_last)
  );

  // Low 2W bits of the product of sign/zero-extended operands are exact.
  logic               mul_sgn;
  logic [2*WIDTH-1:0] a_ext, b_ext, prod;

  assign mul_sgn = (op_q == OP_MULT);
  assign a_ext   = {{WIDTH{mul_sgn & a_q[WIDTH-1]}}, a_q};
  assign b_ext   = {{WIDTH{mul_sgn & b_q[WIDTH-1]}}, b_q};
  assign prod    = a_ext * b_ext;

  logic             div_sgn;
  logic [WIDTH-1:0] q_fix, r_fix;

  assign div_sgn = (op_q == OP_DIV);
  assign q_fix   = (div_sgn & (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quot : quot;
  assign r_fix   = (div_sgn & a_q[WIDTH-1]) ? -rem : rem;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (op_in == OP_MULT || op_in == OP_MULTU)) state_d = ST_MUL;
        else if (div_load)                                     state_d = ST_DIV;
      end
      ST_MUL:  state_d = ST_IDLE;
      ST_DIV: begin
        if (flush_i)       state_d = ST_IDLE;
        else if (div_last) state_d = ST_FIX;
      end
      ST_FIX:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    done  = (state_q == ST_MUL || state_q == ST_FIX) && !flush_i;
    stall = resetn & ((accept & is_md_op(op_i)) | (state_q != ST_IDLE));
    hi_d  = hi_q;
    lo_d  = lo_q;
    if (accept && op_in == OP_MTHI) hi_d = src_a_i;
    if (accept && op_in == OP_MTLO) lo_d = src_a_i;
    if (done && state_q == ST_MUL) {hi_d, lo_d} = prod;
    if (done && state_q == ST_FIX) begin
      if (b_q == '0) begin
        hi_d = a_q;
        lo_d = '1;
      end else begin
        hi_d = r_fix;
        lo_d = q_fix;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_q <= OP_MULT;
      a_q  <= '0;
      b_q  <= '0;
      hi_q <= '0;
      lo_q <= '0;
    end else begin
      if (accept) begin
        op_q <= op_in;
        a_q  <= src_a_i;
        b_q  <= src_b_i;
      end
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end

  assign stall_o = stall;
  assign done_o  = done;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed vectors for hilo_muldiv with hand-computed HI/LO results and timing.
module tb_hilo_muldiv;

  logic        clk, resetn, start_i, flush_i;
  logic [2:0]  op_i;
  logic [31:0] src_a_i, src_b_i;
  logic        stall_o, done_o;
  logic [31:0] hi_o, lo_o;

  int checks = 0;
  int errors = 0;

  hilo_muldiv dut (
    .clk    (clk),
    .resetn (resetn),
    .start_i(start_i),
    .op_i   (op_i),
    .src_a_i(src_a_i),
    .src_b_i(src_b_i),
    .flush_i(flush_i),
    .stall_o(stall_o),
    .done_o (done_o),
    .hi_o   (hi_o),
    .lo_o   (lo_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Issue one op at the current cycle (T0) and run until stall_o drops.
  // Returns in the first cycle with stall_o low, inputs idle.
  task automatic md_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int done_at, output int n_stall, output int n_done);
    done_at = -1; n_stall = 0; n_done = 0;
    start_i = 1'b1; op_i = op; src_a_i = a; src_b_i = b;
    for (int t = 0; t < 40; t++) begin
      #1;
      if (stall_o) n_stall++;
      if (done_o) begin n_done++; done_at = t; end
      if (!stall_o) break;
      @(posedge clk); #1;
      start_i = 1'b0;
    end
  endtask

  int d_at, n_st, n_dn;

  initial begin
    resetn = 1'b0; start_i = 1'b1; op_i = 3'd0; flush_i = 1'b0;
    src_a_i = 32'h1234_5678; src_b_i = 32'h2;
    #2;
    chk("rst_hi", hi_o, 32'h0);
    chk("rst_lo", lo_o, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    chk("rst_done", {31'b0, done_o}, 32'h0);
    @(posedge clk); #1;
    start_i = 1'b0; resetn = 1'b1;
    @(posedge clk); #1;

    // 1. MULT -2 * 3
    md_op(3'd0, 32'hFFFF_FFFE, 32'd3, d_at, n_st, n_dn);
    chk("mult_done_at", d_at, 32'd1);
    chk("mult_nstall", n_st, 32'd2);
    chk("mult_ndone", n_dn, 32'd1);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);

    // 2. MULTU max*max, then MTLO the next cycle
    @(posedge clk); #1;
    md_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, d_at, n_st, n_dn);
    chk("multu_done_at", d_at, 32'd1);
    chk("multu_hi", hi_o, 32'hFFFF_FFFE);
    chk("multu_lo", lo_o, 32'h0000_0001);
    start_i = 1'b1; op_i = 3'd5; src_a_i = 32'd5;
    #1;
    chk("mtlo_stall", {31'b0, stall_o}, 32'h0);
    @(posedge clk); #1;
    start_i = 1'b0;
    #1;
    chk("mtlo_lo", lo_o, 32'd5);
    chk("mtlo_hi", hi_o, 32'hFFFF_FFFE);
    chk("mtlo_done", {31'b0, done_o}, 32'h0);

    // 3. DIV -7 / 2
    @(posedge clk); #1;
    md_op(3'd2, 32'hFFFF_FFF9, 32'd2, d_at, n_st, n_dn);
    chk("div_done_at", d_at, 32'd33);
    chk("div_nstall", n_st, 32'd34);
    chk("div_ndone", n_dn, 32'd1);
    chk("div_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_hi", hi_o, 32'hFFFF_FFFF);

    // 4. divide by zero, overflow case, positive dividend / negative divisor
    @(posedge clk); #1;
    md_op(3'd3, 32'd100, 32'd0, d_at, n_st, n_dn);
    chk("dz_done_at", d_at, 32'd33);
    chk("dz_hi", hi_o, 32'h0000_0064);
    chk("dz_lo", lo_o, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    md_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, d_at, n_st, n_dn);
    chk("ovf_lo", lo_o, 32'h8000_0000);
    chk("ovf_hi", hi_o, 32'h0);
    @(posedge clk); #1;
    md_op(3'd2, 32'd7, 32'hFFFF_FFFE, d_at, n_st, n_dn);
    chk("div7m2_lo", lo_o, 32'hFFFF_FFFD);
    chk("div7m2_hi", hi_o, 32'h1);

    // flush in IDLE suppresses MTHI
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd4; src_a_i = 32'hDEAD_BEEF; flush_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0; flush_i = 1'b0;
    #1;
    chk("flush_idle_hi", hi_o, 32'h1);

    // 5. DIVU 50/7 flushed at T10, then MULTU 6*7 at T11
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 3'd3; src_a_i = 32'd50; src_b_i = 32'd7;
    n_dn = 0;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
      if (t == 10) flush_i = 1'b1;
      #1;
      if (done_o) n_dn++;
    end
    chk("fl_stall_t10", {31'b0, stall_o}, 32'h1);
    chk("fl_ndone", n_dn, 32'd0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    #1;
    chk("fl_stall_t11", {31'b0, stall_o}, 32'h0);
    chk("fl_done_t11", {31'b0, done_o}, 32'h0);
    chk("fl_hi", hi_o, 32'h1);
    chk("fl_lo", lo_o, 32'hFFFF_FFFD);
    md_op(3'd1, 32'd6, 32'd7, d_at, n_st, n_dn);
    chk("fl_mul_done_at", d_at, 32'd1);
    chk("fl_mul_lo", lo_o, 32'd42);
    chk("fl_mul_hi", hi_o, 32'd0);

    // 6. async reset mid-DIV, between clock edges
    @(posedge clk); #1;
    src_a_i = 32'h0000_1234; src_b_i = 32'd1;
    start_i = 1'b1; op_i = 3'd3;
    for (int t = 1; t <= 20; t++) begin
      @(posedge clk); #1;
      start_i = 1'b0;
    end
    #1;
    chk("pre_rst_stall", {31'b0, stall_o}, 32'h1);
    start_i = 1'b1; op_i = 3'd2;
    resetn = 1'b0;
    #1;
    chk("mid_rst_hi", hi_o, 32'h0);
    chk("mid_rst_lo", lo_o, 32'h0);
    chk("mid_rst_stall", {31'b0, stall_o}, 32'h0);
    chk("mid_rst_done", {31'b0, done_o}, 32'h0);
    @(posedge clk); #1;
    start_i = 1'b0;
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_stall", {31'b0, stall_o}, 32'h0);
    md_op(3'd0, 32'd3, 32'hFFFF_FFFF, d_at, n_st, n_dn);
    chk("post_rst_done_at", d_at, 32'd1);
    chk("post_rst_hi", hi_o, 32'hFFFF_FFFF);
    chk("post_rst_lo", lo_o, 32'hFFFF_FFFD);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
